// File: rtl/controller_pkg.sv
// ============================================================================
// controller_pkg: state, opcode, ALU and select encodings for multicycle_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder: maps alu_op plus funct3/funct7b5/op[5] to the ALU operation code
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_decoder
  import controller_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only means subtract for R-type; addi reuses that bit as immediate
          3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller: Moore control FSM for the multicycle RV32I-subset datapath
// Optional: BRANCH_NE_EN lets the BEQ state also resolve bne. Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;
  logic    taken;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    // reset is asynchronous, so strobes must drop without waiting for a clock
    if (!reset) begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
    end
  end

`ifdef BRANCH_NE_EN
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end
`else
  assign taken = zero;
`endif

  assign pc_write = pc_update | (branch & taken);
  assign imm_src  = reset ? imm_src_of(op) : IMM_I;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (alu_control)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller: scoreboard bench, one expected output vector per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [15:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write)
  );

  // {pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b, imm_src, alu_control, reg_write}
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, reg_write};

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic rw);
    return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic f7, input logic op5);
    case (f3)
      3'b000:  return (f7 && op5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic exp_taken(input logic [2:0] f3, input logic z);
`ifdef BRANCH_NE_EN
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return ~z;
    return 1'b0;
`else
    return z;
`endif
  endfunction

  // Entered at a negedge with the DUT in FETCH; cut > 0 stops after that many cycles.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int cut);
    logic [1:0]  imm;
    logic [2:0]  alu;
    logic [15:0] exp;
    int k;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    imm = exp_imm(o);
    alu = exp_alu(f3, f7, o[5]);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0));
    case (o)
      7'b0000011: begin
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0));
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b1));
      end
      7'b0100011: begin
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0));
        sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0));
      end
      7'b0110011: begin
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, alu, 1'b0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1));
      end
      7'b0010011: begin
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, alu, 1'b0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1));
      end
      7'b1101111: begin
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 1'b0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1));
      end
      7'b1100011: begin
        sb.push_back(mk(exp_taken(f3, z), 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm,
                        3'b001, 1'b0));
      end
      default: ;
    endcase
    k = 0;
    while (sb.size() != 0) begin
      exp = sb.pop_front();
      #1;
      check_value(tag, obs, exp);
      k++;
      if (k == cut) begin
        sb.delete();
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_value("reset_hold", obs, 16'h0000);
    end
    reset = 1'b1;

    run_instr("r_add",    7'b0110011, 3'b000, 1'b0, 1'b0, 0);
    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 0);
    run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    run_instr("beq_tk",   7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    run_instr("beq_nt",   7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    run_instr("r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    run_instr("r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, 0);
    run_instr("r_and",    7'b0110011, 3'b111, 1'b0, 1'b0, 0);
    run_instr("r_slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 0);
    run_instr("i_other",  7'b0010011, 3'b011, 1'b1, 1'b0, 0);
    run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 0);
    run_instr("illegal",  7'b0000000, 3'b000, 1'b0, 1'b0, 0);
    run_instr("bne_nz",   7'b1100011, 3'b001, 1'b0, 1'b0, 0);
    run_instr("bne_z",    7'b1100011, 3'b001, 1'b0, 1'b1, 0);

    // Stop inside MEMWRITE and pull reset asynchronously mid-cycle.
    run_instr("sw_cut",   7'b0100011, 3'b010, 1'b0, 1'b0, 4);
    #2 reset = 1'b0;
    #1 check_value("reset_mid", obs, 16'h0000);
    @(negedge clk);
    check_value("reset_mid_hold", obs, 16'h0000);
    reset = 1'b1;
    run_instr("after_rst", 7'b0000011, 3'b000, 1'b0, 1'b0, 0);
    #1 check_value("final_fetch", obs,
                   mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
